tt_rx: RTL and testbench
========================

TT_RX -- requirements
Module: tt_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, rxclk ticks per bit time; legal values 8 or 16 only.
REQ-002 Port: clk  input  1  system clock; all state changes on posedge clk.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: rxclk  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate, from the baud rate generator.
REQ-005 Port: rx_enable  input  1  receiver enable; low forces the receiver idle.
REQ-006 Port: rx_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port: uld_rx_data  input  1  unload request from the DL11 register block; level-held until rx_empty=1 is seen.
REQ-008 Port: rx_data  output  8  holding register, the last accepted byte.
REQ-009 Port: rx_empty  output  1  1 = holding register has no unread byte.
REQ-010 Port: rx_frame_err  output  1  stop bit of the byte in the holding register was sampled low.
REQ-011 Port: rx_overrun  output  1  a completed byte was dropped because the holding register was full.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value (rxs).
REQ-013 The state machine SHALL have the states IDLE, START, DATA and STOP, with a tick counter cnt (log2(OVERSAMPLE) bits) and a bit index bidx (3 bits); cnt and bidx advance only on clk edges where rxclk=1.
REQ-014 IDLE: on an rxclk tick with rxs=0 -> START, cnt=0.
REQ-015 START: on each tick cnt++; at cnt=OVERSAMPLE/2-1, if rxs=0 -> DATA with cnt=0 and bidx=0, else (false start) -> IDLE.
REQ-016 DATA: on each tick cnt++ (wraps); at cnt=OVERSAMPLE-1, shift rxs into shift[7] (right shift, LSB first), then bidx++; after bidx=7 is sampled -> STOP, cnt=0.
REQ-017 STOP: at cnt=OVERSAMPLE-1 the stop bit is sampled, the byte completes, and the state returns to IDLE on the same edge.
REQ-018 Byte completion with rx_empty=1: rx_data<=shift, rx_empty<=0, rx_frame_err<=~rxs, rx_overrun unchanged; outputs are visible the cycle after the stop-sample edge.
REQ-019 Byte completion with rx_empty=0 and uld_rx_data=0: rx_data and rx_frame_err SHALL be kept (new byte discarded), and rx_overrun<=1.
REQ-020 uld_rx_data=1 on an edge with no completion: rx_empty<=1, rx_frame_err<=0, rx_overrun<=0; with rx_empty already 1 there is no effect.
REQ-021 Completion and uld_rx_data=1 on the same edge: the new byte is loaded per REQ-018, rx_empty stays 0, rx_overrun<=0, and no overrun is flagged.
REQ-022 rx_enable=0: state<=IDLE, cnt<=0, bidx<=0 on every edge; holding register, rx_empty and the flags are kept, and uld_rx_data is still honoured.
REQ-023 A framing error SHALL NOT block the receiver; the next falling edge of rxs in IDLE starts a new frame.
REQ-024 A line held low (break) SHALL produce one byte 8'h00 with rx_frame_err=1, then restart only after rxs has been high in IDLE.
REQ-025 Total latency from the start-bit falling edge at rxs to rx_empty=0 SHALL be 9.5 bit times +/-1 rxclk period.

Reset
REQ-026 Reset SHALL asynchronously force: state=IDLE, cnt=0, bidx=0, shift=0, rx_data=8'h00, rx_empty=1, rx_frame_err=0, rx_overrun=0, and both synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no partial byte loaded; after release, reception restarts at the next start bit.

Verification
REQ-028 Byte 8'hA5, valid stop, OVERSAMPLE=16 -> rx_data=8'hA5, rx_empty=0, both flags 0; uld_rx_data pulse -> rx_empty=1 on the next cycle.
REQ-029 rx_in low for 4 rxclk ticks then high -> state returns to IDLE, rx_empty remains 1, no flags set.
REQ-030 Byte 8'h3C with stop bit low -> rx_data=8'h3C, rx_frame_err=1; a following valid byte 8'h0D after unload -> rx_data=8'h0D, rx_frame_err=0.
REQ-031 8'h41 received and not unloaded, then 8'h55 received -> rx_data=8'h41, rx_overrun=1; unload -> rx_empty=1, rx_overrun=0.
REQ-032 uld_rx_data asserted on the exact edge 8'h55 completes while 8'h41 is held -> rx_data=8'h55, rx_empty=0, rx_overrun=0.
REQ-033 reset pulsed during data bit 3 of 8'hFF, then 8'h12 sent -> only 8'h12 appears, rx_empty=0, both flags 0.

Source files
------------

// File: rtl/tt_rx.sv
// tt_rx: oversampling 8N1 UART receiver with a single-byte holding register.
//   clk          system clock
//   reset        asynchronous active-high reset
//   rxclk        one-clk enable pulse at OVERSAMPLE x baud (8 or 16 only)
//   rx_enable    low holds the receiver idle; the holding register is kept
//   rx_in        asynchronous serial line, idle high, LSB first
//   uld_rx_data  unload request, level-held by the register block
//   rx_data      last accepted byte
//   rx_empty     1 = no unread byte
//   rx_frame_err stop bit of the held byte was sampled low
//   rx_overrun   a completed byte was dropped because the register was full
module tt_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxclk,
  input  logic       rx_enable,
  input  logic       rx_in,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_frame_err,
  output logic       rx_overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shift;
  logic          sync1, rxs;
  // Set once rxs is seen high in IDLE, cleared at byte completion. A start
  // therefore needs a genuine falling edge, so a held-low line (break or a
  // low stop bit that lingers) cannot retrigger a frame.
  logic          armed;
  logic          done;

  assign done = rx_enable && rxclk && (state == STOP) && (cnt == CNT_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b1;
      rxs          <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bidx         <= '0;
      shift        <= '0;
      armed        <= 1'b0;
      rx_data      <= 8'h00;
      rx_empty     <= 1'b1;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;

      if (!rx_enable) begin
        state <= IDLE;
        cnt   <= '0;
        bidx  <= '0;
        if (rxs) armed <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rxs) armed <= 1'b1;
            if (rxclk && !rxs && armed) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: if (rxclk) begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              if (!rxs) begin
                state <= DATA;
                bidx  <= '0;
              end else begin
                state <= IDLE;   // false start: glitch shorter than half a bit
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: if (rxclk) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_END) begin
              shift <= {rxs, shift[7:1]};
              bidx  <= bidx + 3'd1;
              if (bidx == 3'd7) begin
                state <= STOP;
                cnt   <= '0;
              end
            end
          end
          STOP: if (rxclk) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_END) begin
              state <= IDLE;
              cnt   <= '0;
              armed <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Holding register. An unload on the completion edge frees the slot
      // for the new byte, so that case loads rather than overruns.
      if (done) begin
        if (rx_empty || uld_rx_data) begin
          rx_data      <= shift;
          rx_empty     <= 1'b0;
          rx_frame_err <= ~rxs;
          if (uld_rx_data) rx_overrun <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (uld_rx_data && !rx_empty) begin
        rx_empty     <= 1'b1;
        rx_frame_err <= 1'b0;
        rx_overrun   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tt_rx.sv
module tb_tt_rx;
  localparam int OS  = 16;
  localparam int DIV = 4;          // clk cycles per rxclk tick
  localparam int BIT = OS * DIV;   // clk cycles per bit time

  logic clk, reset, rxclk, rx_enable, rx_in, uld_rx_data;
  logic [7:0] rx_data;
  logic rx_empty, rx_frame_err, rx_overrun;

  tt_rx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .rxclk(rxclk), .rx_enable(rx_enable),
    .rx_in(rx_in), .uld_rx_data(uld_rx_data), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] div = 2'd0;
  always @(posedge clk) div <= div + 2'd1;
  assign rxclk = (div == 2'd0);

  int tests = 0, fails = 0;

  // Reference model of the holding register, driven by whole-byte events.
  logic [7:0] m_data;
  logic m_empty, m_ferr, m_ovr;

  wire [10:0] obs = {rx_data, rx_empty, rx_frame_err, rx_overrun};
  function automatic logic [10:0] exp_regs();
    return {m_data, m_empty, m_ferr, m_ovr};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_empty = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop, input bit uld_same);
    if (m_empty || uld_same) begin
      m_data = b; m_empty = 1'b0; m_ferr = ~stop;
      if (uld_same) m_ovr = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    if (!m_empty) begin m_empty = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0; end
    repeat (2) @(negedge clk);
  endtask

  task automatic align();
    do @(negedge clk); while (div != 2'd0);
  endtask

  // One 8N1 frame. The falling edge of the start bit is driven just before
  // a tick edge p; the stop sample then lands on edge p+612 (2 sync flops,
  // 1 tick to detect, 8 ticks to mid-start, 9 x 16 ticks of data+stop).
  task automatic send(input logic [7:0] b, input bit stop, input bit uld_edge,
                      input int rst_at);
    logic [9:0] fr;
    int lat;
    bit expect_done;
    bit was_empty;
    fr = {stop, b, 1'b0};
    lat = -1;
    expect_done = rx_enable && (rst_at < 0);
    was_empty = m_empty;
    align();
    for (int c = 0; c < 10 * BIT; c++) begin
      rx_in = fr[c / BIT];
      uld_rx_data = uld_edge && (c == 612);
      reset = (c == rst_at);
      if (lat < 0 && c > 0 && !rx_empty) lat = c - 1;
      @(negedge clk);
    end
    rx_in = 1'b1; uld_rx_data = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);
    if (rst_at >= 0) model_reset();
    if (expect_done) model_byte(b, stop, uld_edge);
    if (expect_done && was_empty) begin
      tests++;
      // lat counts from rx_in; the synchronized line falls one edge later
      if (lat < 0 || (lat - 1) < 608 - DIV || (lat - 1) > 608 + DIV) begin
        fails++;
        $display("FAIL latency byte %h: got %0d clk from rxs fall, want 608 +/- %0d", b, lat - 1, DIV);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; rx_enable = 1'b1; uld_rx_data = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    tests++;
    if (obs !== exp_regs()) begin fails++; $display("FAIL reset_held: got %h want %h", obs, exp_regs()); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (obs !== exp_regs()) begin fails++; $display("FAIL reset_release: got %h want %h", obs, exp_regs()); end
  endtask

  task automatic test_basic();
    send(8'hA5, 1'b1, 1'b0, -1);
    tests++;
    if (obs !== {8'hA5, 3'b000}) begin fails++; $display("FAIL basic_a5: got %h want %h", obs, {8'hA5, 3'b000}); end
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    m_empty = 1'b1;
    tests++;
    if (rx_empty !== 1'b1) begin fails++; $display("FAIL basic_unload_next: got %b want 1", rx_empty); end
  endtask

  task automatic test_false_start();
    align();
    rx_in = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx_in = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    tests++;
    if (obs !== exp_regs()) begin fails++; $display("FAIL false_start: got %h want %h", obs, exp_regs()); end
  endtask

  task automatic test_frame_err();
    send(8'h3C, 1'b0, 1'b0, -1);
    tests++;
    if (obs !== {8'h3C, 3'b010}) begin fails++; $display("FAIL ferr_3c: got %h want %h", obs, {8'h3C, 3'b010}); end
    unload();
    send(8'h0D, 1'b1, 1'b0, -1);
    tests++;
    if (obs !== {8'h0D, 3'b000}) begin fails++; $display("FAIL ferr_next_0d: got %h want %h", obs, {8'h0D, 3'b000}); end
    unload();
  endtask

  task automatic test_overrun();
    send(8'h41, 1'b1, 1'b0, -1);
    send(8'h55, 1'b1, 1'b0, -1);
    tests++;
    if (obs !== {8'h41, 3'b001}) begin fails++; $display("FAIL overrun_set: got %h want %h", obs, {8'h41, 3'b001}); end
    unload();
    tests++;
    if (obs !== {8'h41, 3'b100}) begin fails++; $display("FAIL overrun_unload: got %h want %h", obs, {8'h41, 3'b100}); end
  endtask

  task automatic test_same_edge();
    send(8'h41, 1'b1, 1'b0, -1);
    send(8'h55, 1'b1, 1'b1, -1);
    tests++;
    if (obs !== {8'h55, 3'b000}) begin fails++; $display("FAIL same_edge: got %h want %h", obs, {8'h55, 3'b000}); end
    unload();
  endtask

  task automatic test_break();
    align();
    rx_in = 1'b0;
    repeat (13 * BIT) @(negedge clk);
    rx_in = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    model_byte(8'h00, 1'b0, 1'b0);
    tests++;
    if (obs !== {8'h00, 3'b010}) begin fails++; $display("FAIL break: got %h want %h", obs, {8'h00, 3'b010}); end
    unload();
    send(8'hC3, 1'b1, 1'b0, -1);
    tests++;
    if (obs !== {8'hC3, 3'b000}) begin fails++; $display("FAIL after_break: got %h want %h", obs, {8'hC3, 3'b000}); end
    unload();
  endtask

  task automatic test_enable();
    send(8'h5A, 1'b1, 1'b0, -1);
    rx_enable = 1'b0;
    send(8'h66, 1'b1, 1'b0, -1);
    tests++;
    if (obs !== {8'h5A, 3'b000}) begin fails++; $display("FAIL disabled_hold: got %h want %h", obs, {8'h5A, 3'b000}); end
    unload();
    tests++;
    if (obs !== {8'h5A, 3'b100}) begin fails++; $display("FAIL disabled_unload: got %h want %h", obs, {8'h5A, 3'b100}); end
    rx_enable = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    send(8'hFF, 1'b1, 1'b0, 4 * BIT + BIT / 2);
    tests++;
    if (obs !== {8'h00, 3'b100}) begin fails++; $display("FAIL midframe_reset: got %h want %h", obs, {8'h00, 3'b100}); end
    send(8'h12, 1'b1, 1'b0, -1);
    tests++;
    if (obs !== {8'h12, 3'b000}) begin fails++; $display("FAIL after_reset_12: got %h want %h", obs, {8'h12, 3'b000}); end
    unload();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit stop;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send(b, stop, 1'b0, -1);
      tests++;
      if (obs !== exp_regs()) begin fails++; $display("FAIL random_%0d byte %h: got %h want %h", i, b, obs, exp_regs()); end
      if ($urandom_range(0, 1) == 1) begin
        unload();
        tests++;
        if (obs !== exp_regs()) begin fails++; $display("FAIL random_unload_%0d: got %h want %h", i, obs, exp_regs()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_same_edge();
    test_break();
    test_enable();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
